// File: rtl/kid_pkg.sv
// Shared definitions for the kid_group hunger channels: state encoding and
// width helpers used to size timers and counters from the parameters.
package kid_pkg;

    typedef enum logic [1:0] {
        ST_ILLEGAL = 2'b00,
        HUNGRY     = 2'b01,
        FULL       = 2'b10,
        STUDY      = 2'b11
    } kid_state_t;

    function automatic int kid_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // $clog2 with a floor of one bit so degenerate parameters still give a legal vector
    function automatic int kid_clog2_min1(input int v);
        int w;
        w = $clog2(v);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/kid_fsm.sv
// One hunger channel: HUNGRY/FULL/STUDY state, shared digestion/study timer,
// saturating starvation counter, and the registered request/starve flags.
module kid_fsm
    import kid_pkg::*;
#(
    parameter int FULL_CYCLES  = 8,
    parameter int STUDY_CYCLES = 4,
    parameter int STARVE_LIMIT = 16,
    parameter int TW           = 3,
    parameter int SW           = 5
) (
    input  logic clk,
    input  logic resetb,
    input  logic grant,
    input  logic book,
    output logic request,
    output logic starve
);

    kid_state_t        state_r;
    kid_state_t        state_s;
    logic [TW-1:0]     timer_r;
    logic [TW-1:0]     timer_s;
    logic [SW-1:0]     cnt_r;
    logic [SW-1:0]     cnt_s;

    // Next-state, timer and starvation-counter computation
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        case (state_r)
            HUNGRY: begin
                if (grant) begin
                    state_s = FULL;
                    timer_s = TW'(FULL_CYCLES - 1);
                end else begin
                    state_s = HUNGRY;
                end
            end
            FULL: begin
                // a book in the last FULL cycle still wins over digestion expiry
                if (book) begin
                    state_s = STUDY;
                    timer_s = TW'(STUDY_CYCLES - 1);
                end else if (timer_r == TW'(0)) begin
                    state_s = HUNGRY;
                end else begin
                    timer_s = timer_r - TW'(1);
                end
            end
            STUDY: begin
                if (timer_r == TW'(0)) begin
                    state_s = HUNGRY;
                end else begin
                    timer_s = timer_r - TW'(1);
                end
            end
            default: begin
                state_s = HUNGRY;
                timer_s = '0;
            end
        endcase

        if ((state_r == HUNGRY) && (state_s == HUNGRY)) begin
            cnt_s = (cnt_r == SW'(STARVE_LIMIT)) ? cnt_r : (cnt_r + SW'(1));
        end else begin
            cnt_s = '0;
        end
    end

    // State, timer, counter and the request/starve output flops
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_r <= HUNGRY;
            timer_r <= '0;
            cnt_r   <= '0;
            request <= 1'b0;
            starve  <= 1'b0;
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
            cnt_r   <= cnt_s;
            request <= (state_s == HUNGRY);
            starve  <= (cnt_s == SW'(STARVE_LIMIT));
        end
    end

endmodule

// File: rtl/kid_group.sv
// NUM_KIDS hunger channels sharing one meal producer through a round-robin
// arbiter with a valid/ready handshake.
module kid_group
    import kid_pkg::*;
#(
    parameter int NUM_KIDS     = 4,
    parameter int FULL_CYCLES  = 8,
    parameter int STUDY_CYCLES = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                            clk,
    input  logic                            resetb,
    input  logic                            meal_valid,
    output logic                            meal_ready,
    output logic [NUM_KIDS-1:0]             meal_grant,
    input  logic [NUM_KIDS-1:0]             book,
    output logic [NUM_KIDS-1:0]             request,
    output logic [NUM_KIDS-1:0]             starve,
    output logic [$clog2(NUM_KIDS+1)-1:0]   hungry_cnt
);

    localparam int TW = kid_clog2_min1(kid_max(FULL_CYCLES, STUDY_CYCLES));
    localparam int SW = kid_clog2_min1(STARVE_LIMIT + 1);
    localparam int PW = kid_clog2_min1(NUM_KIDS);
    localparam int CW = $clog2(NUM_KIDS + 1);

    logic [PW-1:0] rr_ptr_r;
    logic [PW-1:0] winner_s;
    logic          found_s;
    logic          transfer_s;
    int            idx_s;

    assign meal_ready = |request;
    assign transfer_s = meal_valid & meal_ready;

    // Round-robin search starting at rr_ptr; grant only on an actual transfer
    always_comb begin
        winner_s   = '0;
        found_s    = 1'b0;
        idx_s      = 0;
        meal_grant = '0;
        for (int off = 0; off < NUM_KIDS; off++) begin
            idx_s = int'(rr_ptr_r) + off;
            if (idx_s >= NUM_KIDS) begin
                idx_s = idx_s - NUM_KIDS;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && request[idx_s[PW-1:0]]) begin
                found_s  = 1'b1;
                winner_s = idx_s[PW-1:0];
            end else begin
                found_s  = found_s;
            end
        end
        if (transfer_s && found_s) begin
            meal_grant[winner_s] = 1'b1;
        end else begin
            meal_grant = '0;
        end
    end

    // Pointer moves just past the winner on a transfer, holds otherwise
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rr_ptr_r <= '0;
        end else if (transfer_s) begin
            if (winner_s == PW'(NUM_KIDS - 1)) begin
                rr_ptr_r <= '0;
            end else begin
                rr_ptr_r <= winner_s + PW'(1);
            end
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Population count of hungry kids
    always_comb begin
        hungry_cnt = '0;
        for (int i = 0; i < NUM_KIDS; i++) begin
            hungry_cnt = hungry_cnt + CW'(request[i]);
        end
    end

    for (genvar g = 0; g < NUM_KIDS; g++) begin : g_kid
        kid_fsm #(
            .FULL_CYCLES  (FULL_CYCLES),
            .STUDY_CYCLES (STUDY_CYCLES),
            .STARVE_LIMIT (STARVE_LIMIT),
            .TW           (TW),
            .SW           (SW)
        ) u_kid (
            .clk     (clk),
            .resetb  (resetb),
            .grant   (meal_grant[g]),
            .book    (book[g]),
            .request (request[g]),
            .starve  (starve[g])
        );
    end

endmodule

// File: tb/tb_kid_group.sv
// Directed bench for kid_group with default parameters (4 kids, 8/4/16).
module tb_kid_group;

    logic       clk;
    logic       resetb;
    logic       meal_valid;
    logic       meal_ready;
    logic [3:0] meal_grant;
    logic [3:0] book;
    logic [3:0] request;
    logic [3:0] starve;
    logic [2:0] hungry_cnt;

    int errors;
    int checks;

    kid_group #(
        .NUM_KIDS     (4),
        .FULL_CYCLES  (8),
        .STUDY_CYCLES (4),
        .STARVE_LIMIT (16)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .meal_valid (meal_valid),
        .meal_ready (meal_ready),
        .meal_grant (meal_grant),
        .book       (book),
        .request    (request),
        .starve     (starve),
        .hungry_cnt (hungry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        resetb     = 1'b0;
        meal_valid = 1'b0;
        book       = 4'b0000;

        // T1a: reset state
        tick(2);
        check("rst_request", 32'(request), 32'h0);
        check("rst_starve", 32'(starve), 32'h0);
        check("rst_ready", 32'(meal_ready), 32'h0);
        check("rst_grant", 32'(meal_grant), 32'h0);
        check("rst_hcnt", 32'(hungry_cnt), 32'h0);

        // release; first edge raises every request
        resetb = 1'b1;
        tick(1);                                   // edge 1
        check("rel_request", 32'(request), 32'hF);
        check("rel_hcnt", 32'(hungry_cnt), 32'h4);
        check("rel_ready", 32'(meal_ready), 32'h1);

        // T5: starvation after 16 hungry cycles
        tick(14);                                  // edge 15
        check("starve_e15", 32'(starve), 32'h0);
        tick(1);                                   // edge 16
        check("starve_e16", 32'(starve), 32'hF);

        // T2: round-robin, starve bit clears with its grant
        meal_valid = 1'b1;
        #1;
        check("rr_g0", 32'(meal_grant), 32'h1);
        tick(1);                                   // edge 17
        check("rr_req1", 32'(request), 32'hE);
        check("rr_stv1", 32'(starve), 32'hE);
        check("rr_g1", 32'(meal_grant), 32'h2);
        tick(1);                                   // edge 18
        check("rr_req2", 32'(request), 32'hC);
        check("rr_stv2", 32'(starve), 32'hC);
        check("rr_g2", 32'(meal_grant), 32'h4);
        tick(1);                                   // edge 19
        check("rr_req3", 32'(request), 32'h8);
        check("rr_stv3", 32'(starve), 32'h8);
        check("rr_g3", 32'(meal_grant), 32'h8);
        tick(1);                                   // edge 20

        // T6: backpressure with everyone full
        check("bp_req", 32'(request), 32'h0);
        check("bp_stv", 32'(starve), 32'h0);
        check("bp_ready", 32'(meal_ready), 32'h0);
        check("bp_grant", 32'(meal_grant), 32'h0);
        check("bp_hcnt", 32'(hungry_cnt), 32'h0);

        // T3: kid0 digests for exactly 8 cycles (entered FULL on edge 17)
        tick(4);                                   // edge 24: last FULL cycle
        check("dig_e24_req", 32'(request), 32'h0);
        check("dig_e24_grant", 32'(meal_grant), 32'h0);
        meal_valid = 1'b0;
        tick(1);                                   // edge 25
        check("dig_e25_req", 32'(request), 32'h1);
        check("dig_e25_hcnt", 32'(hungry_cnt), 32'h1);
        tick(1);                                   // edge 26
        check("dig_e26_req", 32'(request), 32'h3);
        meal_valid = 1'b1;
        #1;
        check("rr_ptr_held", 32'(meal_grant), 32'h1);
        tick(1);                                   // edge 27: kid0 FULL again
        meal_valid = 1'b0;
        #1;
        check("e27_req", 32'(request), 32'h6);
        check("e27_grant", 32'(meal_grant), 32'h0);
        tick(1);                                   // edge 28
        check("e28_req", 32'(request), 32'hE);

        // T4: book on FULL's final cycle wins over expiry
        tick(6);                                   // edge 34: kid0 timer==0
        check("e34_req", 32'(request), 32'hE);
        book = 4'b1111;
        tick(1);                                   // edge 35: kid0 STUDY
        book = 4'b0000;
        check("study_e35", 32'(request), 32'hE);
        tick(1);                                   // edge 36
        book = 4'b0001;
        tick(1);                                   // edge 37: book ignored in STUDY
        book = 4'b0000;
        check("study_e37", 32'(request), 32'hE);
        tick(1);                                   // edge 38
        check("study_e38", 32'(request), 32'hE);
        tick(1);                                   // edge 39: back to HUNGRY
        check("study_e39", 32'(request), 32'hF);
        check("study_hcnt", 32'(hungry_cnt), 32'h4);
        check("study_stv", 32'(starve), 32'h0);
        meal_valid = 1'b1;
        #1;
        check("rejoin_grant", 32'(meal_grant), 32'h2);

        // T1b: reset mid-run aborts the pending transfer
        resetb = 1'b0;
        #1;
        check("mid_req", 32'(request), 32'h0);
        check("mid_stv", 32'(starve), 32'h0);
        check("mid_ready", 32'(meal_ready), 32'h0);
        check("mid_grant", 32'(meal_grant), 32'h0);
        tick(1);
        resetb = 1'b1;
        tick(1);
        check("mid_rel_req", 32'(request), 32'hF);
        check("mid_rel_hcnt", 32'(hungry_cnt), 32'h4);
        check("mid_rr_reset", 32'(meal_grant), 32'h1);
        tick(1);
        check("mid_after_req", 32'(request), 32'hE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
